s9234_n676_state: RTL and testbench
===================================

# s9234_n676_state

Sequential stage directly downstream of the combinational n676 next-state cone for s9234. It registers the cone's output into the g676 state flip-flop. That registered value is fed back to the cone as its `g676` input. The stage also lockstep-compares the primary cone against a duplicated cone, counts mismatches, and raises an alarm that freezes the state on persistent disagreement. Its purpose is fault-injection and reliability measurement on the n676 cone.

## Interface
Parameters:
- `CNT_W`, 8: width of the saturating mismatch counter.
- `SAMP_W`, 16: width of the enabled-sample counter and the first-fail index.
- `ALARM_THRESH`, 3: number of consecutive enabled mismatches that enters ALARM. Legal range is 1..15.
- `RESET_VAL`, 1'b0: reset value of `g676`.

Ports:
- `clock`, input, 1: the single clock. Every register changes on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: sample strobe. The block samples the cone outputs only on cycles where `en`=1.
- `n676`, input, 1: next-state value from the primary cone.
- `n676_dup`, input, 1: next-state value from the duplicated cone.
- `clr_err`, input, 1: synchronous clear of the error state and counters.
- `g676`, output, 1: registered state, fed back to the cone.
- `err_flag`, output, 1: sticky. Set by the first mismatch after reset or clear.
- `alarm`, output, 1: 1 while the FSM is in ALARM.
- `err_cnt`, output, CNT_W: saturating count of enabled mismatches.
- `samp_cnt`, output, SAMP_W: count of enabled samples. Wraps.
- `first_fail`, output, SAMP_W: value of `samp_cnt` at the first mismatch.

## Operation
- Mismatch definition: `mm = en & (n676 ^ n676_dup)`. A match is `en` with both inputs equal.
- FSM states:
  - RUN: `g676` <= `n676` on every `en` cycle, whether the sample is a match or a mismatch. `g676` holds when `en`=0.
  - ALARM: `g676` holds regardless of `en`. Comparison, `samp_cnt` and `err_cnt` keep updating.
- Streak counter: 4 bits, internal.
  - +1 on `mm`, saturating at 15.
  - Cleared on an enabled match.
  - Unchanged when `en`=0.
- RUN -> ALARM when the streak's next value equals `ALARM_THRESH`. `alarm` is 1 from that edge onward.
- ALARM -> RUN only on `clr_err`. A later match in ALARM does not leave ALARM.
- `err_cnt`: +1 on `mm`, saturating at 2^CNT_W-1.
- `samp_cnt`: +1 on every `en` cycle. Wraps from all-ones to 0.
- `first_fail` and `err_flag`: on `mm` with `err_flag`=0, `first_fail` <= current (pre-increment) `samp_cnt` and `err_flag` <= 1. Otherwise `first_fail` holds.
- `clr_err` has priority over everything in the same cycle. It:
  - clears `err_cnt`, the streak, `err_flag`, `first_fail` and `samp_cnt`;
  - moves the FSM to RUN;
  - discards any concurrent `mm`.
  - `g676` still loads `n676` if `en`=1, because the next state is RUN.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - `g676`=`RESET_VAL`; `err_flag`=0; `alarm`=0; `err_cnt`=0; `samp_cnt`=0; `first_fail`=0.
  - Streak = 0 and FSM = RUN.
  - Reset asserted mid-ALARM returns immediately to these values.
- Latency:
  - `n676` to `g676`: 1 cycle.
  - `mm` to `err_flag`, `err_cnt` and `alarm`: 1 cycle.
- All outputs come straight from registers. There is no combinational path from inputs to outputs.
- Reset deassertion is synchronised externally. The first edge after deassertion is a normal cycle.

## Test plan
- Reset then run: `reset_n` low, release; drive `en`=1 with `n676`=`n676_dup`=1,0,1. Required: `g676` goes 0 (reset value), then 1,0,1 each one cycle late; `err_cnt`=0; `samp_cnt`=3.
- Single mismatch: after 5 matched samples, inject `n676`=1, `n676_dup`=0 once. Required:
  - next cycle `err_flag`=1, `err_cnt`=1, `first_fail`=5, `alarm`=0;
  - `g676`=1 (primary value taken);
  - a following match clears the streak.
- Alarm entry and freeze: 3 consecutive enabled mismatches, with an `en`=0 cycle between the 2nd and 3rd. Required:
  - `alarm`=1 after the 3rd;
  - `g676` holds its value through 4 further enabled samples of opposite value;
  - `err_cnt` continues to increment.
- Clear priority: in ALARM, assert `clr_err` together with a mismatch and `en`=1, `n676`=0. Required next cycle: `alarm`=0, `err_flag`=0, `err_cnt`=0, `samp_cnt`=0, `g676`=0.
- Saturation and wrap: with `CNT_W`=2 and `SAMP_W`=3, drive 10 mismatches. Required: `err_cnt` stays at 3 and `samp_cnt` reads 2 (10 mod 8).
- Asynchronous reset mid-ALARM: pulse `reset_n` low between clock edges. Required: all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/s9234_n676_state_if.sv
// Bus bundle for the s9234 g676 state stage: sample strobe,
// primary/duplicate cone values, clear, and the registered status.
interface s9234_n676_state_if #(
    parameter int CNT_W  = 8,
    parameter int SAMP_W = 16
);
    logic              en;
    logic              n676;
    logic              n676_dup;
    logic              clr_err;
    logic              g676;
    logic              err_flag;
    logic              alarm;
    logic [CNT_W-1:0]  err_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [SAMP_W-1:0] first_fail;

    modport master (
        output en, n676, n676_dup, clr_err,
        input  g676, err_flag, alarm, err_cnt, samp_cnt, first_fail
    );

    modport slave (
        input  en, n676, n676_dup, clr_err,
        output g676, err_flag, alarm, err_cnt, samp_cnt, first_fail
    );
endinterface

// File: rtl/s9234_n676_state.sv
// g676 state flop with lockstep compare against a duplicated n676 cone,
// mismatch counters and an alarm that freezes the state.
module s9234_n676_state #(
    parameter int   CNT_W        = 8,
    parameter int   SAMP_W       = 16,
    parameter int   ALARM_THRESH = 3,
    parameter logic RESET_VAL    = 1'b0
) (
    input logic               clock,
    input logic               reset_n,
    s9234_n676_state_if.slave bus
);

    typedef enum logic {RUN, ALARM} state_t;

    localparam logic [3:0]       THRESH  = 4'(ALARM_THRESH);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_t            state_q, state_d;
    logic              g_q, g_d;
    logic              flag_q, flag_d;
    logic              alarm_q, alarm_d;
    logic [3:0]        streak_q, streak_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic [SAMP_W-1:0] ff_q, ff_d;
    logic              mm;
    logic              match;

    always_comb begin
        mm       = bus.en & (bus.n676 ^ bus.n676_dup);
        match    = bus.en & ~(bus.n676 ^ bus.n676_dup);
        state_d  = state_q;
        g_d      = g_q;
        flag_d   = flag_q;
        streak_d = streak_q;
        err_d    = err_q;
        samp_d   = samp_q;
        ff_d     = ff_q;
        if (bus.clr_err) begin
            // Clear wins; the next state is RUN so an enabled sample still loads.
            state_d  = RUN;
            streak_d = '0;
            err_d    = '0;
            samp_d   = '0;
            ff_d     = '0;
            flag_d   = 1'b0;
            if (bus.en) g_d = bus.n676;
        end else begin
            if (state_q == RUN && bus.en) g_d = bus.n676;
            if (bus.en) samp_d = samp_q + SAMP_W'(1);
            if (mm) begin
                if (err_q != ERR_MAX) err_d = err_q + CNT_W'(1);
                if (streak_q != 4'hf) streak_d = streak_q + 4'd1;
                if (!flag_q) begin
                    flag_d = 1'b1;
                    ff_d   = samp_q;
                end
            end else if (match) begin
                streak_d = '0;
            end
            if (state_q == RUN && streak_d == THRESH) state_d = ALARM;
        end
        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            g_q      <= RESET_VAL;
            flag_q   <= 1'b0;
            alarm_q  <= 1'b0;
            streak_q <= '0;
            err_q    <= '0;
            samp_q   <= '0;
            ff_q     <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            flag_q   <= flag_d;
            alarm_q  <= alarm_d;
            streak_q <= streak_d;
            err_q    <= err_d;
            samp_q   <= samp_d;
            ff_q     <= ff_d;
        end
    end

    assign bus.g676       = g_q;
    assign bus.err_flag   = flag_q;
    assign bus.alarm      = alarm_q;
    assign bus.err_cnt    = err_q;
    assign bus.samp_cnt   = samp_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_s9234_n676_state.sv
// Bench for s9234_n676_state: directed table, corner sequences and
// random stimulus against a behavioural model, two parameter sets.
module tb_s9234_n676_state;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    s9234_n676_state_if #(.CNT_W(8), .SAMP_W(16)) ifa ();
    s9234_n676_state_if #(.CNT_W(2), .SAMP_W(3))  ifb ();

    assign ifb.en       = ifa.en;
    assign ifb.n676     = ifa.n676;
    assign ifb.n676_dup = ifa.n676_dup;
    assign ifb.clr_err  = ifa.clr_err;

    s9234_n676_state #(.CNT_W(8), .SAMP_W(16), .ALARM_THRESH(3), .RESET_VAL(1'b0))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
    s9234_n676_state #(.CNT_W(2), .SAMP_W(3), .ALARM_THRESH(3), .RESET_VAL(1'b0))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int g, flag, alarm, err, samp, ff, streak;
    } model_t;

    typedef struct {
        bit e, n, d, c;
        int g, f, a, err, samp, ff;
    } vec_t;

    model_t ma, mb;
    vec_t   tbl[$];

    function automatic model_t mzero();
        model_t r;
        r = '{0, 0, 0, 0, 0, 0, 0};
        return r;
    endfunction

    // Behavioural reference: plain integer arithmetic on the operating rules.
    function automatic model_t mstep(model_t m, bit e, bit n, bit d, bit c,
                                     int cw, int sw);
        model_t r;
        bit mm;
        r  = m;
        mm = e && (n != d);
        if (c) begin
            r = mzero();
            r.g = e ? int'(n) : m.g;
            return r;
        end
        if (m.alarm == 0 && e) r.g = int'(n);
        if (e) r.samp = (m.samp + 1) % (1 << sw);
        if (mm) begin
            r.err    = (m.err + 1 > (1 << cw) - 1) ? (1 << cw) - 1 : m.err + 1;
            r.streak = (m.streak + 1 > 15) ? 15 : m.streak + 1;
            if (m.flag == 0) begin
                r.flag = 1;
                r.ff   = m.samp;
            end
        end else if (e) begin
            r.streak = 0;
        end
        if (m.alarm == 0 && r.streak == 3) r.alarm = 1;
        return r;
    endfunction

    task automatic check_a(string nm);
        logic [42:0] got, exp;
        got = {ifa.g676, ifa.err_flag, ifa.alarm, ifa.err_cnt,
               ifa.samp_cnt, ifa.first_fail};
        exp = {1'(ma.g), 1'(ma.flag), 1'(ma.alarm), 8'(ma.err),
               16'(ma.samp), 16'(ma.ff)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (g,flag,alarm,err,samp,ff)",
                     nm, got, exp);
        end
    endtask

    task automatic check_b(string nm);
        logic [10:0] got, exp;
        got = {ifb.g676, ifb.err_flag, ifb.alarm, ifb.err_cnt,
               ifb.samp_cnt, ifb.first_fail};
        exp = {1'(mb.g), 1'(mb.flag), 1'(mb.alarm), 2'(mb.err),
               3'(mb.samp), 3'(mb.ff)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (g,flag,alarm,err,samp,ff)",
                     nm, got, exp);
        end
    endtask

    task automatic cyc(bit e, bit n, bit d, bit c);
        ifa.en       = e;
        ifa.n676     = n;
        ifa.n676_dup = d;
        ifa.clr_err  = c;
        @(posedge clock);
        ma = mstep(ma, e, n, d, c, 8, 16);
        mb = mstep(mb, e, n, d, c, 2, 3);
        #1;
        check_a("model_a");
        check_b("model_b");
    endtask

    task automatic addv(bit e, bit n, bit d, bit c,
                        int g, int f, int a, int err, int samp, int ff);
        vec_t v;
        v = '{e, n, d, c, g, f, a, err, samp, ff};
        tbl.push_back(v);
    endtask

    task automatic check_const_a(string nm, int g, int f, int a,
                                 int err, int samp, int ff);
        logic [42:0] got, exp;
        got = {ifa.g676, ifa.err_flag, ifa.alarm, ifa.err_cnt,
               ifa.samp_cnt, ifa.first_fail};
        exp = {1'(g), 1'(f), 1'(a), 8'(err), 16'(samp), 16'(ff)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (g,flag,alarm,err,samp,ff)",
                     nm, got, exp);
        end
    endtask

    initial begin
        // e n d c : g flag alarm err samp ff
        addv(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        addv(1, 1, 1, 0, 1, 0, 0, 0, 3, 0);
        addv(1, 1, 1, 0, 1, 0, 0, 0, 4, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        addv(1, 1, 0, 0, 1, 1, 0, 1, 6, 5);
        addv(1, 0, 0, 0, 0, 1, 0, 1, 7, 5);
        addv(1, 1, 0, 0, 1, 1, 0, 2, 8, 5);
        addv(1, 0, 1, 0, 0, 1, 0, 3, 9, 5);
        addv(0, 1, 1, 0, 0, 1, 0, 3, 9, 5);
        addv(1, 1, 0, 0, 1, 1, 1, 4, 10, 5);
        addv(1, 0, 1, 0, 1, 1, 1, 5, 11, 5);
        addv(1, 0, 1, 0, 1, 1, 1, 6, 12, 5);
        addv(1, 0, 1, 0, 1, 1, 1, 7, 13, 5);
        addv(1, 0, 1, 0, 1, 1, 1, 8, 14, 5);
        addv(1, 0, 0, 0, 1, 1, 1, 8, 15, 5);
        addv(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        ifa.en = 0; ifa.n676 = 0; ifa.n676_dup = 0; ifa.clr_err = 0;
        reset_n = 1'b0;
        ma = mzero();
        mb = mzero();
        repeat (2) @(posedge clock);
        #1;
        check_const_a("reset_a", 0, 0, 0, 0, 0, 0);
        check_b("reset_b");
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].e, tbl[i].n, tbl[i].d, tbl[i].c);
            check_const_a($sformatf("table_%0d", i), tbl[i].g, tbl[i].f,
                          tbl[i].a, tbl[i].err, tbl[i].samp, tbl[i].ff);
        end

        for (int i = 0; i < 10; i++) cyc(1, i[0], ~i[0], 0);
        tests++;
        if (ifb.err_cnt !== 2'd3) begin
            fails++;
            $display("FAIL sat_err_b: got %0d required 3", ifb.err_cnt);
        end
        tests++;
        if (ifb.samp_cnt !== 3'd2) begin
            fails++;
            $display("FAIL wrap_samp_b: got %0d required 2", ifb.samp_cnt);
        end
        tests++;
        if (ifa.alarm !== 1'b1) begin
            fails++;
            $display("FAIL alarm_before_rst: got %b required 1", ifa.alarm);
        end

        #2 reset_n = 1'b0;
        #1;
        ma = mzero();
        mb = mzero();
        check_const_a("async_rst_a", 0, 0, 0, 0, 0, 0);
        check_b("async_rst_b");
        #1 reset_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            bit e, n, d, c;
            e = ($urandom_range(0, 3) != 0);
            n = 1'($urandom);
            d = ($urandom_range(0, 3) == 0) ? ~n : n;
            c = ($urandom_range(0, 40) == 0);
            cyc(e, n, d, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
